// File: rtl/interdevice_tx_arbiter_pkg.sv
// Shared types for the interdevice transmit arbiter: flit layout, arbiter state and constants.
package interdevice_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        FlitHead     = 2'd0,
        FlitBody     = 2'd1,
        FlitTail     = 2'd2,
        FlitHeadTail = 2'd3
    } flit_type_t;

    typedef struct packed {
        flit_type_t  flit_type;
        logic [5:0]  dest;
    } flit_header_t;

    typedef struct packed {
        flit_header_t header;
        logic [31:0]  payload;
    } flit_t;

    typedef enum logic {
        StIdle,
        StLocked
    } arb_state_t;

    localparam int unsigned TimeoutDefault = 64;
    localparam int unsigned CntW           = 8;

    // A flit that may open a packet (and so may win arbitration).
    function automatic logic is_head(flit_type_t t);
        return (t == FlitHead) || (t == FlitHeadTail);
    endfunction

    // A flit whose acceptance closes the packet.
    function automatic logic is_last(flit_type_t t);
        return (t == FlitTail) || (t == FlitHeadTail);
    endfunction

endpackage

// File: rtl/interdevice_tx_arbiter_rr_priority_pick.sv
// Round-robin priority pick: first set request scanning upward from ptr, wrapping at N.
module rr_priority_pick #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Walk offsets 0..N-1 from ptr; the first hit wins.
    always_comb begin
        int j;
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = 0; k < int'(N); k++) begin
            j = (int'(ptr) + k) % int'(N);
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/interdevice_tx_arbiter.sv
// Shares the interdevice tx port between NUM_REQ requesters with packet-locked round robin,
// an idle-owner watchdog and saturating debug counters.
module interdevice_tx_arbiter
    import interdevice_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = TimeoutDefault,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                       cpuclk,
    input  logic                       rst_n,
    input  flit_t [NUM_REQ-1:0]        req_flit,
    input  logic  [NUM_REQ-1:0]        req_valid,
    output logic  [NUM_REQ-1:0]        req_ready,
    output flit_t                      tx_flit,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic  [ID_W-1:0]           grant_id,
    output logic                       busy,
    output logic  [CntW-1:0]           timeout_count,
    output logic  [CntW-1:0]           proto_err_count
);

    localparam int unsigned WdogW = $clog2(TIMEOUT);

    arb_state_t        state_q, state_d;
    logic [ID_W-1:0]   owner_q, owner_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [WdogW-1:0]  wdog_q, wdog_d;
    logic [CntW-1:0]   timeout_cnt_q, timeout_cnt_d;
    logic [CntW-1:0]   proto_err_cnt_q, proto_err_cnt_d;

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] misplaced;
    logic               pick_found;
    logic [ID_W-1:0]    pick_idx;
    flit_t              owner_flit;
    logic               owner_valid;
    logic               owner_done;
    logic               wdog_fire;
    logic [ID_W-1:0]    owner_next;

    // Classify every offered flit: packet openers compete, stray body/tail flits get dropped.
    always_comb begin
        eligible  = '0;
        misplaced = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            eligible[i]  = req_valid[i] && is_head(req_flit[i].header.flit_type);
            misplaced[i] = req_valid[i] && !is_head(req_flit[i].header.flit_type);
        end
    end

    rr_priority_pick #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_pick (
        .req   (eligible),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Owner-side conditions that end a lock.
    always_comb begin
        owner_flit  = req_flit[owner_q];
        owner_valid = req_valid[owner_q];
        owner_done  = (state_q == StLocked) && owner_valid && tx_ready
                      && is_last(owner_flit.header.flit_type);
        // Only fires with valid low, so an offered flit is never withdrawn from downstream.
        wdog_fire   = (state_q == StLocked) && !owner_valid
                      && (wdog_q == WdogW'(TIMEOUT - 1));
        owner_next  = (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + ID_W'(1);
    end

    // State register plus watchdog, pointer and counter state.
    always_ff @(posedge cpuclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            owner_q         <= '0;
            rr_ptr_q        <= '0;
            wdog_q          <= '0;
            timeout_cnt_q   <= '0;
            proto_err_cnt_q <= '0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            rr_ptr_q        <= rr_ptr_d;
            wdog_q          <= wdog_d;
            timeout_cnt_q   <= timeout_cnt_d;
            proto_err_cnt_q <= proto_err_cnt_d;
        end
    end

    // Next-state: arbitrate in IDLE, hold the lock until tail handshake or watchdog release.
    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        rr_ptr_d        = rr_ptr_q;
        wdog_d          = wdog_q;
        timeout_cnt_d   = timeout_cnt_q;
        proto_err_cnt_d = proto_err_cnt_q;
        unique case (state_q)
            StIdle: begin
                wdog_d = '0;
                if (pick_found) begin
                    state_d = StLocked;
                    owner_d = pick_idx;
                end
                if ((|misplaced) && (proto_err_cnt_q != '1)) begin
                    proto_err_cnt_d = proto_err_cnt_q + CntW'(1);
                end
            end
            StLocked: begin
                if (owner_done) begin
                    state_d  = StIdle;
                    rr_ptr_d = owner_next;
                    wdog_d   = '0;
                end else if (wdog_fire) begin
                    state_d  = StIdle;
                    rr_ptr_d = owner_next;
                    wdog_d   = '0;
                    if (timeout_cnt_q != '1) begin
                        timeout_cnt_d = timeout_cnt_q + CntW'(1);
                    end
                end else if (owner_valid) begin
                    wdog_d = '0;
                end else begin
                    wdog_d = wdog_q + WdogW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs: owner passthrough when locked, drop-acks for stray flits when idle.
    always_comb begin
        tx_flit   = '0;
        tx_valid  = 1'b0;
        req_ready = '0;
        unique case (state_q)
            StIdle: begin
                // Gated so ready is low for the whole time reset is held.
                req_ready = rst_n ? misplaced : '0;
            end
            StLocked: begin
                tx_flit            = owner_flit;
                tx_valid           = owner_valid;
                req_ready[owner_q] = tx_ready;
            end
            default: ;
        endcase
        grant_id        = owner_q;
        busy            = (state_q == StLocked);
        timeout_count   = timeout_cnt_q;
        proto_err_count = proto_err_cnt_q;
    end

endmodule
